csrbrg_burst: RTL

- Wishbone slave that bridges the system Wishbone interconnect onto the on-chip CSR bus used by peripheral control registers.
- Sits on one slave port of the Wishbone arbiter/decoder.
- Converts Wishbone classic cycles into single-cycle CSR write strobes and fixed-latency CSR reads.
- Optionally pipelines incrementing read bursts.

---
 rtl/csrbrg_burst_if.sv | 22 ++
 rtl/csrbrg_burst.sv | 105 ++++++++++
 2 files changed

// File: rtl/csrbrg_burst_if.sv
// Wishbone slave-side signal bundle for the CSR bridge.
interface csrbrg_burst_if;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic [2:0]  wb_cti_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_ack_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_cti_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/csrbrg_burst.sv
// Wishbone classic slave to CSR bus bridge with fixed-latency reads.
// Define CSRBRG_BURST_EN to pipeline incrementing (cti=010) read bursts.
module csrbrg_burst #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CSR_AW       = 14
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    csrbrg_burst_if.slave     wb,
    output logic [CSR_AW-1:0] csr_a,
    output logic              csr_we,
    output logic [31:0]       csr_do,
    input  logic [31:0]       csr_di
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WRITE = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_ACK   = 3'd3;
`ifdef CSRBRG_BURST_EN
    localparam logic [2:0] ST_BURST = 3'd4;
`endif

    logic [2:0] state;
    logic [2:0] rd_cnt;
`ifdef CSRBRG_BURST_EN
    // bit i set: the address presented i cycles ago is still in flight
    logic [READ_LATENCY:0] vld;
`endif

    // Byte-lane and out-of-window address bits are decoded by the interconnect.
    logic unused_bits;
    assign unused_bits = ^{wb.wb_adr_i[31:CSR_AW+2], wb.wb_adr_i[1:0], wb.wb_cti_i};

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= ST_IDLE;
            rd_cnt      <= '0;
            wb.wb_ack_o <= 1'b0;
            wb.wb_dat_o <= '0;
            csr_a       <= '0;
            csr_we      <= 1'b0;
            csr_do      <= '0;
`ifdef CSRBRG_BURST_EN
            vld         <= '0;
`endif
        end else begin
            csr_we      <= 1'b0;
            wb.wb_ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wb.wb_cyc_i && wb.wb_stb_i) begin
                        csr_a <= wb.wb_adr_i[CSR_AW+1:2];
                        if (wb.wb_we_i) begin
                            // Partial-select writes are acked but never reach the CSR bus.
                            csr_do      <= wb.wb_dat_i;
                            csr_we      <= (wb.wb_sel_i == 4'hF);
                            wb.wb_ack_o <= 1'b1;
                            state       <= ST_WRITE;
`ifdef CSRBRG_BURST_EN
                        end else if (wb.wb_cti_i == 3'b010) begin
                            vld   <= {{READ_LATENCY{1'b0}}, 1'b1};
                            state <= ST_BURST;
`endif
                        end else begin
                            rd_cnt <= 3'(READ_LATENCY);
                            state  <= ST_READ;
                        end
                    end
                end
                ST_WRITE: state <= ST_IDLE;
                ST_READ: begin
                    if (!wb.wb_cyc_i) begin
                        state <= ST_IDLE;
                    end else if (rd_cnt == 3'd0) begin
                        wb.wb_dat_o <= csr_di;
                        wb.wb_ack_o <= 1'b1;
                        state       <= ST_ACK;
                    end else begin
                        rd_cnt <= rd_cnt - 3'd1;
                    end
                end
                ST_ACK: state <= ST_IDLE;
`ifdef CSRBRG_BURST_EN
                ST_BURST: begin
                    // Last beat acked or master gone: drop everything still in flight.
                    if (!wb.wb_cyc_i || (wb.wb_ack_o && wb.wb_cti_i != 3'b010)) begin
                        vld   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        csr_a <= csr_a + CSR_AW'(1);
                        vld   <= {vld[READ_LATENCY-1:0], 1'b1};
                        if (vld[READ_LATENCY]) begin
                            wb.wb_dat_o <= csr_di;
                            wb.wb_ack_o <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
